// File: rtl/branch_predictor.sv
// branch_predictor: dynamic IF-stage predictor built from a BTB and a 2-bit PHT.
// The PHT is indexed bimodally (MODE 0) or gshare-style (MODE 1) through a
// speculative global history register.
// Ports:
//   clk, rst          clock and synchronous active-low reset
//   pred_valid/pc     fetch lookup request; stall blocks the speculative GHR shift
//   pred_hit/taken/   combinational lookup result and next fetch PC
//   pred_target
//   pred_ghr          GHR snapshot that travels down the pipe with the instruction
//   update_*          resolution from EX (PHT/BTB training and GHR repair)
//   perf_br_cnt       saturating count of resolved control-flow instructions
//   perf_mispred_cnt  saturating count of mispredicts
module branch_predictor #(
  parameter int unsigned ENTRIES  = 64,
  parameter int unsigned GHR_BITS = 6,
  parameter int unsigned TAG_BITS = 8,
  parameter int unsigned MODE     = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pred_valid,
  input  logic [31:0]         pred_pc,
  input  logic                stall,
  output logic                pred_hit,
  output logic                pred_taken,
  output logic [31:0]         pred_target,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                update_valid,
  input  logic [31:0]         update_pc,
  input  logic                update_is_br,
  input  logic                update_taken,
  input  logic [31:0]         update_target,
  input  logic                update_mispredict,
  input  logic [GHR_BITS-1:0] update_ghr,
  output logic [31:0]         perf_br_cnt,
  output logic [31:0]         perf_mispred_cnt
);

  localparam int unsigned IDX = $clog2(ENTRIES);

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [31:0]         target;
    logic                uncond;
  } btb_entry_t;

  btb_entry_t          btb_q [ENTRIES];
  logic [1:0]          pht_q [ENTRIES];
  logic [GHR_BITS-1:0] ghr_q;
  logic [31:0]         br_cnt_q;
  logic [31:0]         mispred_cnt_q;

  logic [IDX-1:0]      pred_bi;
  logic [IDX-1:0]      pred_pi;
  logic [IDX-1:0]      upd_bi;
  logic [IDX-1:0]      upd_pi;
  logic [TAG_BITS-1:0] pred_tag;
  logic [TAG_BITS-1:0] upd_tag;
  btb_entry_t          pred_e;
  logic                spec_shift;
  logic                unused_ok;

  // Index/tag extraction; gshare folds the history into the low index bits
  assign pred_bi  = pred_pc[IDX+1:2];
  assign pred_tag = pred_pc[IDX+TAG_BITS+1:IDX+2];
  assign upd_bi   = update_pc[IDX+1:2];
  assign upd_tag  = update_pc[IDX+TAG_BITS+1:IDX+2];
  assign pred_pi  = (MODE == 1) ? (pred_bi ^ IDX'(ghr_q))      : pred_bi;
  assign upd_pi   = (MODE == 1) ? (upd_bi  ^ IDX'(update_ghr)) : upd_bi;

  // PC bits outside index/tag are intentionally ignored
  assign unused_ok = ^{pred_pc, update_pc};

  // Combinational lookup against registered state
  assign pred_e      = btb_q[pred_bi];
  assign pred_hit    = pred_e.valid && (pred_e.tag == pred_tag);
  assign pred_taken  = pred_hit && (pred_e.uncond || pht_q[pred_pi][1]);
  assign pred_target = pred_taken ? pred_e.target : pred_pc + 32'd4;
  assign pred_ghr    = ghr_q;

  assign perf_br_cnt      = br_cnt_q;
  assign perf_mispred_cnt = mispred_cnt_q;

  // Only conditional branches that hit shift speculative history
  assign spec_shift = pred_valid && !stall && pred_hit && !pred_e.uncond;

  // Tables: training on resolution, full clear on reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        btb_q[IDX'(i)] <= '0;
        pht_q[IDX'(i)] <= 2'b01;
      end
    end else if (update_valid) begin
      if (update_is_br) begin
        if (update_taken) begin
          if (pht_q[upd_pi] != 2'b11) pht_q[upd_pi] <= pht_q[upd_pi] + 2'd1;
        end else begin
          if (pht_q[upd_pi] != 2'b00) pht_q[upd_pi] <= pht_q[upd_pi] - 2'd1;
        end
      end
      if (update_taken) begin
        btb_q[upd_bi] <= '{valid: 1'b1, tag: upd_tag, target: update_target,
                           uncond: !update_is_br};
      end
    end
  end

  // GHR: mispredict repair beats speculative shift; concat-then-truncate keeps
  // the low GHR_BITS so the GHR_BITS == 1 case needs no special handling
  always_ff @(posedge clk) begin
    if (!rst) begin
      ghr_q <= '0;
    end else if (update_valid && update_mispredict) begin
      ghr_q <= update_is_br ? GHR_BITS'({update_ghr, update_taken}) : update_ghr;
    end else if (spec_shift) begin
      ghr_q <= GHR_BITS'({ghr_q, pred_taken});
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else if (update_valid) begin
      if (br_cnt_q != '1) br_cnt_q <= br_cnt_q + 32'd1;
      if (update_mispredict && (mispred_cnt_q != '1)) mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a gshare instance (g_*) and a bimodal
// instance (b_*) share one stimulus stream.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        stall;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_is_br;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_mispredict;
  logic [5:0]  update_ghr;

  logic        g_hit, g_taken, b_hit, b_taken;
  logic [31:0] g_target, b_target, g_br, g_mis, b_br, b_mis;
  logic [5:0]  g_ghr, b_ghr;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(64), .GHR_BITS(6), .TAG_BITS(8), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_pc(pred_pc), .stall(stall),
    .pred_hit(g_hit), .pred_taken(g_taken), .pred_target(g_target), .pred_ghr(g_ghr),
    .update_valid(update_valid), .update_pc(update_pc), .update_is_br(update_is_br),
    .update_taken(update_taken), .update_target(update_target),
    .update_mispredict(update_mispredict), .update_ghr(update_ghr),
    .perf_br_cnt(g_br), .perf_mispred_cnt(g_mis)
  );

  branch_predictor #(.ENTRIES(64), .GHR_BITS(6), .TAG_BITS(8), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_pc(pred_pc), .stall(stall),
    .pred_hit(b_hit), .pred_taken(b_taken), .pred_target(b_target), .pred_ghr(b_ghr),
    .update_valid(update_valid), .update_pc(update_pc), .update_is_br(update_is_br),
    .update_taken(update_taken), .update_target(update_target),
    .update_mispredict(update_mispredict), .update_ghr(update_ghr),
    .perf_br_cnt(b_br), .perf_mispred_cnt(b_mis)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic br, input logic tk,
                         input logic [31:0] tgt, input logic mis, input logic [5:0] g);
    update_valid      = 1'b1;
    update_pc         = pc;
    update_is_br      = br;
    update_taken      = tk;
    update_target     = tgt;
    update_mispredict = mis;
    update_ghr        = g;
  endtask

  task automatic clr_upd();
    update_valid      = 1'b0;
    update_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    logic [5:0] train_ghr [3];
    train_ghr = '{6'd0, 6'd1, 6'd3};
    rst = 1'b0; pred_valid = 1'b0; pred_pc = '0; stall = 1'b0;
    update_valid = 1'b0; update_pc = '0; update_is_br = 1'b0; update_taken = 1'b0;
    update_target = '0; update_mispredict = 1'b0; update_ghr = '0;
    @(negedge clk);
    do_reset();

    // Reset state
    pred_pc = 32'h100; #1;
    check("rst_hit",    32'(g_hit),    32'd0);
    check("rst_taken",  32'(g_taken),  32'd0);
    check("rst_target", g_target,      32'h104);
    check("rst_ghr",    32'(g_ghr),    32'd0);
    check("rst_br",     g_br,          32'd0);
    check("rst_mis",    g_mis,         32'd0);

    // jal allocation
    set_upd(32'h100, 1'b0, 1'b1, 32'h200, 1'b0, 6'd0);
    tick(); clr_upd();
    pred_valid = 1'b1; pred_pc = 32'h100; #1;
    check("jal_hit",    32'(g_hit),   32'd1);
    check("jal_taken",  32'(g_taken), 32'd1);
    check("jal_target", g_target,     32'h200);
    pred_pc = 32'h200; #1;
    check("alias_hit",    32'(g_hit), 32'd0);
    check("alias_target", g_target,   32'h204);
    pred_pc = 32'h100;
    tick();
    check("jal_no_shift", 32'(g_ghr), 32'd0);
    check("jal_br_cnt",   g_br,       32'd1);
    pred_valid = 1'b0;

    // Bimodal counter behaviour
    do_reset();
    set_upd(32'h40, 1'b1, 1'b1, 32'h80, 1'b0, 6'd0);
    pred_pc = 32'h40; #1;
    check("bi_same_cycle_hit", 32'(b_hit), 32'd0);
    tick(); clr_upd(); #1;
    check("bi_t1_hit",    32'(b_hit),   32'd1);
    check("bi_t1_taken",  32'(b_taken), 32'd1);
    check("bi_t1_target", b_target,     32'h80);
    set_upd(32'h40, 1'b1, 1'b0, 32'h80, 1'b0, 6'd0); #1;
    check("bi_same_cycle_old", 32'(b_taken), 32'd1);
    tick(); clr_upd(); #1;
    check("bi_nt1_taken",  32'(b_taken), 32'd0);
    check("bi_nt1_target", b_target,     32'h44);
    for (int i = 0; i < 2; i++) begin
      set_upd(32'h40, 1'b1, 1'b0, 32'h80, 1'b0, 6'd0);
      tick(); clr_upd();
    end
    #1;
    check("bi_sat0_hit",   32'(b_hit),   32'd1);
    check("bi_sat0_taken", 32'(b_taken), 32'd0);
    set_upd(32'h40, 1'b1, 1'b1, 32'h80, 1'b0, 6'd0);
    tick(); clr_upd(); #1;
    check("bi_sat0_up1", 32'(b_taken), 32'd0);
    set_upd(32'h40, 1'b1, 1'b1, 32'h80, 1'b0, 6'd0);
    tick(); clr_upd(); #1;
    check("bi_sat0_up2", 32'(b_taken), 32'd1);

    // gshare speculation, stall, repair
    do_reset();
    foreach (train_ghr[k]) begin
      set_upd(32'h40, 1'b1, 1'b1, 32'h80, 1'b0, train_ghr[k]);
      tick(); clr_upd();
    end
    pred_valid = 1'b1; pred_pc = 32'h40; stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("gs_spec_taken", 32'(g_taken), 32'd1);
      tick();
    end
    check("gs_ghr_111", 32'(g_ghr), 32'h07);
    stall = 1'b1; #1;
    check("gs_stall_hit", 32'(g_hit), 32'd1);
    tick();
    check("gs_stall_hold", 32'(g_ghr), 32'h07);
    stall = 1'b0;
    set_upd(32'h40, 1'b1, 1'b0, 32'h80, 1'b1, 6'b000001);
    tick(); clr_upd(); pred_valid = 1'b0;
    check("gs_repair",   32'(g_ghr), 32'h02);
    check("gs_br_cnt",   g_br,       32'd4);
    check("gs_mis_cnt",  g_mis,      32'd1);

    // Perf counters and saturation
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_upd(32'h100, 1'b0, 1'b1, 32'h300, (i == 1 || i == 3), 6'h15);
      tick(); clr_upd();
    end
    check("perf_br5",   g_br,       32'd5);
    check("perf_mis2",  g_mis,      32'd2);
    check("jal_repair", 32'(g_ghr), 32'h15);
    force dut1.br_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut1.br_cnt_q;
    #1;
    check("perf_preload", g_br, 32'hFFFF_FFFF);
    set_upd(32'h100, 1'b0, 1'b1, 32'h300, 1'b0, 6'd0);
    tick(); clr_upd();
    check("perf_sat",     g_br,  32'hFFFF_FFFF);
    check("perf_sat_mis", g_mis, 32'd2);

    // Reset wins over a same-cycle update
    rst = 1'b0;
    set_upd(32'h100, 1'b0, 1'b1, 32'h200, 1'b1, 6'h2A);
    tick();
    rst = 1'b1; clr_upd();
    pred_pc = 32'h100; #1;
    check("rr_hit",    32'(g_hit),  32'd0);
    check("rr_target", g_target,    32'h104);
    check("rr_ghr",    32'(g_ghr),  32'd0);
    check("rr_br",     g_br,        32'd0);
    check("rr_mis",    g_mis,       32'd0);
    check("rr_bi_hit", 32'(b_hit),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the IF stage, replacing static not-taken prediction in the pipelined RV32I core. It holds a BTB (tag, target, branch type) and a pattern history table of 2-bit saturating counters, indexed either bimodally or gshare-style through a speculative global history register (GHR). Lookup is combinational on the fetch PC. Updates and GHR repair arrive from EX when a control-flow instruction resolves.

## Interface
- ENTRIES, 64: BTB and PHT depth; power of 2, 4 to 1024. IDX = log2(ENTRIES).
- GHR_BITS, 6: global history length; 1 to IDX.
- TAG_BITS, 8: BTB tag width; IDX + TAG_BITS <= 30.
- MODE, 1: 0 = bimodal (PHT indexed by PC only), 1 = gshare.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-low
- pred_valid  in  1  fetch is issuing pred_pc this cycle
- pred_pc  in  32  IF-stage PC
- stall  in  1  pipeline stalled; suppresses speculative GHR shift
- pred_hit  out  1  BTB hit for pred_pc
- pred_taken  out  1  predict redirect
- pred_target  out  32  next fetch PC
- pred_ghr  out  GHR_BITS  GHR snapshot, carried down the pipe with the instruction
- update_valid  in  1  EX resolved a br/jal this cycle
- update_pc  in  32  PC of the resolved instruction
- update_is_br  in  1  1 = conditional branch, 0 = jal
- update_taken  in  1  actual outcome
- update_target  in  32  actual target
- update_mispredict  in  1  prediction was wrong; flush in progress
- update_ghr  in  GHR_BITS  pred_ghr snapshot that travelled with the instruction
- perf_br_cnt  out  32  resolved control-flow count
- perf_mispred_cnt  out  32  mispredict count

## Operation
- BTB index: bi = pc[IDX+1:2]. Tag: pc[IDX+TAG_BITS+1:IDX+2]. Each entry holds valid, tag, target[31:0], and uncond (1 = jal).
- PHT index:
  - MODE 0: bi.
  - MODE 1: bi XOR zero-extended GHR. Lookups use the live GHR; updates use update_ghr.
- Lookup (combinational):
  - pred_hit = valid && tag match.
  - pred_taken = pred_hit && (uncond || pht[idx][1]).
  - pred_target = pred_taken ? btb.target : pred_pc + 4 (32-bit wrap).
  - pred_ghr = current GHR.
- Update when update_valid:
  - If update_is_br: PHT counter at the update index saturates up on taken, down on not-taken. Range 00..11; no wrap.
  - If update_taken: write the BTB entry with valid = 1, new tag, update_target, uncond = !update_is_br. This overwrites any alias.
  - Not-taken branches never allocate BTB entries and never invalidate them.
- GHR, in priority order:
  1. Reset.
  2. update_valid && update_mispredict: GHR <= update_is_br ? {update_ghr[GHR_BITS-2:0], update_taken} : update_ghr. When GHR_BITS = 1, the shift is just {update_taken}.
  3. pred_valid && !stall && pred_hit && !uncond: GHR <= {GHR[GHR_BITS-2:0], pred_taken}.
  4. Otherwise hold.
- In MODE 0 the GHR is still maintained; it only feeds pred_ghr.
- Perf counters:
  - perf_br_cnt += 1 on update_valid.
  - perf_mispred_cnt += 1 on update_valid && update_mispredict.
  - Both saturate at 0xFFFF_FFFF.

## Timing
- Lookup latency 0: outputs are a combinational function of pred_pc and the registered state.
- An update becomes visible to lookups on the cycle after update_valid. A same-cycle lookup at the same index sees the old state.
- A GHR change is visible on pred_ghr and in the gshare index one cycle later.
- Reset (rst = 0 at an edge) overrides any same-cycle update and applies to every entry:
  - all BTB valid = 0;
  - all PHT counters = 01 (weakly not-taken);
  - GHR = 0;
  - perf counters = 0.
- Output values after reset: pred_hit = 0, pred_taken = 0, pred_target = pred_pc + 4, pred_ghr = 0, perf outputs = 0.
- Reset asserted mid-operation discards any in-flight update. The state after reset is identical to power-on reset.
- Simultaneous mispredict repair and speculative shift: the repair wins and the speculative shift is dropped.
- Simultaneous update and lookup at an aliasing index: the lookup uses the pre-write entry; the write lands.
- No other handshake: update_valid is a one-cycle pulse per resolved instruction, and the block has no backpressure.

## Test plan
Defaults throughout (ENTRIES = 64, GHR_BITS = 6, TAG_BITS = 8, MODE = 1) unless noted.
- Reset, then pred_pc = 0x100 -> pred_hit = 0, pred_taken = 0, pred_target = 0x104, pred_ghr = 0, perf counters = 0.
- jal update at 0x100 (taken, target 0x200). Next cycle:
  - lookup 0x100 -> hit = 1, taken = 1, target = 0x200;
  - lookup 0x200 (same index, different tag) -> hit = 0, target = 0x204;
  - GHR unchanged on jal lookups.
- MODE 0, branch at 0x40 (target 0x80):
  - one taken update -> counter 10, lookup taken = 1, target = 0x80;
  - three not-taken updates -> counter 00 and held there, hit = 1, taken = 0;
  - a same-cycle lookup during the first update still returns the old counter.
- GHR speculation and repair:
  - three hit, predicted-taken branch lookups with stall = 0 -> pred_ghr = 0b000111;
  - a lookup with stall = 1 -> no shift;
  - mispredict update with update_ghr = 0b000001, is_br = 1, taken = 0, plus a concurrent speculative lookup -> pred_ghr = 0b000010 next cycle.
- Perf counters: 5 updates, 2 flagged mispredict -> perf_br_cnt = 5, perf_mispred_cnt = 2. With perf_br_cnt forced to 0xFFFF_FFFF, a further update keeps it at 0xFFFF_FFFF.
- Assert rst = 0 in the same cycle as a taken update at 0x100 -> next cycle lookup 0x100 -> hit = 0, GHR = 0, perf counters = 0.
